cmac_tx_arbiter: RTL and testbench
==================================

# cmac_tx_arbiter

Packet-granular round-robin arbiter that shares the CMAC's single TX AXI-Stream port between two requesters. It sits between two upstream packet sources and the CMAC `axis_tx` interface, on `rx_clk`. It gates traffic on PCS alignment: while the link is down, whole packets are consumed and discarded so upstream never stalls. Optional statistics counters report forwarded and dropped packets.

## Interface
- `DATA_WBITS`, 512: tdata width; tkeep is `DATA_WBITS/8`.
- `rx_clk`  in  1  sole clock, 322.265625 MHz CMAC user clock.
- `rx_reset`  in  1  reset; synchronous to `rx_clk`, active-high. Driven from `rx_reset_out` of the CMAC control block.
- `link_up`  in  1  PCS alignment, already synchronous to `rx_clk` (`sync_rx_aligned`).
- `axis_in0_tdata/tkeep/tlast/tuser/tvalid`  in  DATA_WBITS/KW/1/1/1  requester 0 stream.
- `axis_in0_tready`  out  1  requester 0 ready.
- `axis_in1_*`  same widths as `axis_in0_*`  requester 1 stream.
- `axis_out_tdata/tkeep/tlast/tuser/tvalid`  out  DATA_WBITS/KW/1/1/1  to CMAC `axis_tx`.
- `axis_out_tready`  in  1  CMAC ready.
- `pkt_count0`, `pkt_count1`  out  32  packets forwarded per port (stats build only).
- `drop_count`  out  32  packets discarded while link down (stats build only).

## Operation
- Registers:
  - `state` ∈ {IDLE, SEND, DROP}.
  - `grant`: 1 bit, selected port.
  - `prio`: 1 bit, port with priority on the next arbitration.
- IDLE:
  - All treadys are 0 and `axis_out_tvalid` is 0.
  - Candidate selection: if `axis_in[prio]_tvalid`, choose `prio`. Otherwise, if the other port's tvalid is set, choose the other port. Otherwise stay in IDLE.
  - On a choice, set `grant` to the chosen port. Next state is SEND if `link_up`=1, DROP if `link_up`=0.
- SEND:
  - `axis_out_*` is a combinational copy of `axis_in[grant]_*`.
  - `axis_in[grant]_tready` = `axis_out_tready`; the non-granted tready is 0.
  - On a beat with tlast (tvalid & tready & tlast): set `prio` = ~`grant` and go to IDLE.
- DROP:
  - `axis_in[grant]_tready` = 1 and `axis_out_tvalid` = 0.
  - On a beat with tlast: set `prio` = ~`grant` and go to IDLE.
- `link_up` is sampled only in IDLE.
  - If the link is lost mid-packet in SEND, the packet still completes to the CMAC, which discards it with `ctl_tx_enable` low.
  - If the link is regained mid-packet in DROP, the packet is still discarded. This prevents a truncated packet from reaching the CMAC.
- Packets are never interleaved. A new grant happens only after tlast.
- tuser is carried unmodified (CMAC TX error flag).
- Reset:
  - `state`=IDLE, `grant`=0, `prio`=0.
  - All treadys 0, `axis_out_tvalid` 0.
  - Counters 0.
  - Reset mid-packet abandons the packet. The upstream source must also be reset.

## Timing
- Arbitration bubble: exactly 1 cycle in IDLE between the tlast beat of one packet and the first beat of the next.
- Throughput: one packet of N beats occupies N+1 cycles at minimum.
- Datapath latency: 0 cycles. Output data, tvalid and tready are purely combinational from the granted input/output in SEND, so there is no skid buffer.
- `axis_out_tvalid` never depends on `axis_out_tready`. Per AXI-Stream, tvalid is not withdrawn once asserted, because the granted source obeys AXI.
- Simultaneous tvalid on both ports in IDLE: `prio` wins.
- Back-to-back demand on both ports: strict alternation 0,1,0,1…
- Counters:
  - Update on the cycle after the tlast handshake (registered).
  - Saturate at 0xFFFFFFFF; no wrap.

## Configuration
- `CMAC_TX_ARB_STATS_EN` defined:
  - `pkt_count0/1` increment on each forwarded tlast for the matching `grant`.
  - `drop_count` increments on each DROP-state tlast.
- Not defined: the counter logic is removed and the three count ports are tied to 0. Arbitration behaviour is identical.

## Test plan
- Single port, link up: port0 sends a 4-beat packet with `axis_out_tready`=1.
  - `axis_out` shows the 4 beats unmodified, starting 1 cycle after tvalid rises.
  - `pkt_count0`=1.
- Contention: both ports hold 3-beat packets continuously for 8 packets.
  - Output order is 0,1,0,1,0,1,0,1.
  - Each gap is exactly 1 idle cycle.
  - `pkt_count0`=`pkt_count1`=4.
- Backpressure: toggle `axis_out_tready` every cycle during a 5-beat packet.
  - Beats are delivered in order with no duplication or loss.
  - Input tready mirrors output tready.
- Link down: `link_up`=0 and port1 sends two 2-beat packets.
  - `axis_out_tvalid` stays 0 and `axis_in1_tready`=1 during DROP.
  - `drop_count`=2.
- Link transitions mid-packet:
  - Drop `link_up` during beat 2 of a 6-beat SEND: all 6 beats are forwarded.
  - Raise `link_up` during beat 2 of a DROP: the whole packet is discarded and the next packet is forwarded.
- Reset mid-packet: assert `rx_reset` for 1 cycle during beat 3.
  - Next cycle: all outputs are at reset values and counters are 0.
  - The first new packet is granted to port0 when both ports are valid.

Source files
------------

// File: rtl/cmac_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the CMAC axis_tx port.
// Optional stats counters: define CMAC_TX_ARB_STATS_EN.
module cmac_tx_arbiter #(
  parameter int DATA_WBITS = 512
) (
  input  logic                    rx_clk,
  input  logic                    rx_reset,
  input  logic                    link_up,

  input  logic [DATA_WBITS-1:0]   axis_in0_tdata,
  input  logic [DATA_WBITS/8-1:0] axis_in0_tkeep,
  input  logic                    axis_in0_tlast,
  input  logic                    axis_in0_tuser,
  input  logic                    axis_in0_tvalid,
  output logic                    axis_in0_tready,

  input  logic [DATA_WBITS-1:0]   axis_in1_tdata,
  input  logic [DATA_WBITS/8-1:0] axis_in1_tkeep,
  input  logic                    axis_in1_tlast,
  input  logic                    axis_in1_tuser,
  input  logic                    axis_in1_tvalid,
  output logic                    axis_in1_tready,

  output logic [DATA_WBITS-1:0]   axis_out_tdata,
  output logic [DATA_WBITS/8-1:0] axis_out_tkeep,
  output logic                    axis_out_tlast,
  output logic                    axis_out_tuser,
  output logic                    axis_out_tvalid,
  input  logic                    axis_out_tready,

  output logic [31:0]             pkt_count0,
  output logic [31:0]             pkt_count1,
  output logic [31:0]             drop_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0] r_state;
  logic       r_grant;
  logic       r_prio;

  logic w_send;
  logic w_drop;
  logic w_g_tvalid;
  logic w_g_tlast;
  logic w_g_tready;
  logic w_last_beat;
  logic w_req_p;
  logic w_req_o;
  logic w_pick;

  always_comb begin
    w_send      = (r_state == S_SEND);
    w_drop      = (r_state == S_DROP);
    w_g_tvalid  = r_grant ? axis_in1_tvalid : axis_in0_tvalid;
    w_g_tlast   = r_grant ? axis_in1_tlast  : axis_in0_tlast;
    w_g_tready  = w_drop | (w_send & axis_out_tready);
    w_last_beat = w_g_tvalid & w_g_tready & w_g_tlast;
    w_req_p     = r_prio ? axis_in1_tvalid : axis_in0_tvalid;
    w_req_o     = r_prio ? axis_in0_tvalid : axis_in1_tvalid;
    w_pick      = w_req_p ? r_prio : ~r_prio;
  end

  // Zero-latency passthrough; tvalid is gated only by state, never by tready
  always_comb begin
    axis_out_tdata  = r_grant ? axis_in1_tdata : axis_in0_tdata;
    axis_out_tkeep  = r_grant ? axis_in1_tkeep : axis_in0_tkeep;
    axis_out_tlast  = w_g_tlast;
    axis_out_tuser  = r_grant ? axis_in1_tuser : axis_in0_tuser;
    axis_out_tvalid = w_send & w_g_tvalid;
    axis_in0_tready = ~r_grant & w_g_tready;
    axis_in1_tready =  r_grant & w_g_tready;
  end

  // link_up is only consulted at grant time so packets are never truncated
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      r_state <= S_IDLE;
      r_grant <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_p | w_req_o) begin
            r_grant <= w_pick;
            r_state <= link_up ? S_SEND : S_DROP;
          end
        end
        S_SEND, S_DROP: begin
          if (w_last_beat) begin
            r_prio  <= ~r_grant;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CMAC_TX_ARB_STATS_EN
  logic [31:0] r_pkt0;
  logic [31:0] r_pkt1;
  logic [31:0] r_drop;

  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      r_pkt0 <= 32'd0;
      r_pkt1 <= 32'd0;
      r_drop <= 32'd0;
    end else if (w_last_beat) begin
      if (w_send & ~r_grant & (r_pkt0 != 32'hFFFF_FFFF))
        r_pkt0 <= r_pkt0 + 32'd1;
      if (w_send & r_grant & (r_pkt1 != 32'hFFFF_FFFF))
        r_pkt1 <= r_pkt1 + 32'd1;
      if (w_drop & (r_drop != 32'hFFFF_FFFF))
        r_drop <= r_drop + 32'd1;
    end
  end

  assign pkt_count0 = r_pkt0;
  assign pkt_count1 = r_pkt1;
  assign drop_count = r_drop;
`else
  assign pkt_count0 = 32'd0;
  assign pkt_count1 = 32'd0;
  assign drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_cmac_tx_arbiter.sv
// Directed bench for cmac_tx_arbiter; bench-side source model and
// expected-beat queue. Counter expectations follow CMAC_TX_ARB_STATS_EN.
module tb_cmac_tx_arbiter;

  logic         rx_clk;
  logic         rx_reset;
  logic         link_up;
  logic [511:0] in0_tdata, in1_tdata, out_tdata;
  logic [63:0]  in0_tkeep, in1_tkeep, out_tkeep;
  logic         in0_tlast, in0_tuser, in0_tvalid, in0_tready;
  logic         in1_tlast, in1_tuser, in1_tvalid, in1_tready;
  logic         out_tlast, out_tuser, out_tvalid, out_tready;
  logic [31:0]  pkt_count0, pkt_count1, drop_count;

  cmac_tx_arbiter #(.DATA_WBITS(512)) dut (
    .rx_clk          (rx_clk),
    .rx_reset        (rx_reset),
    .link_up         (link_up),
    .axis_in0_tdata  (in0_tdata),
    .axis_in0_tkeep  (in0_tkeep),
    .axis_in0_tlast  (in0_tlast),
    .axis_in0_tuser  (in0_tuser),
    .axis_in0_tvalid (in0_tvalid),
    .axis_in0_tready (in0_tready),
    .axis_in1_tdata  (in1_tdata),
    .axis_in1_tkeep  (in1_tkeep),
    .axis_in1_tlast  (in1_tlast),
    .axis_in1_tuser  (in1_tuser),
    .axis_in1_tvalid (in1_tvalid),
    .axis_in1_tready (in1_tready),
    .axis_out_tdata  (out_tdata),
    .axis_out_tkeep  (out_tkeep),
    .axis_out_tlast  (out_tlast),
    .axis_out_tuser  (out_tuser),
    .axis_out_tvalid (out_tvalid),
    .axis_out_tready (out_tready),
    .pkt_count0      (pkt_count0),
    .pkt_count1      (pkt_count1),
    .drop_count      (drop_count)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int s_len[2];
  int s_beat[2];
  int s_pkt[2];
  int s_left[2];

  logic [639:0] exp_q[$];
  bit mon_en    = 1'b1;
  bit out_sop   = 1'b1;
  bit gap_en    = 1'b0;
  bit bp_chk    = 1'b0;
  bit bp_tog    = 1'b0;
  bit noout_chk = 1'b0;
  int last_tl   = -1;
  int lk_port   = -1;
  logic lk_val  = 1'b0;

  function automatic logic [31:0] ce(input int v);
`ifdef CMAC_TX_ARB_STATS_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [511:0] dat(input int p, input int k, input int b);
    return {16{8'(p), 8'(k), 16'(b)}};
  endfunction

  function automatic logic [63:0] kp(input logic l);
    return l ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [639:0] beat(input int p, input int k,
                                        input int b, input int len);
    logic l;
    l = (b == len - 1);
    return {62'b0, l & (k % 2 == 1), l, kp(l), dat(p, k, b)};
  endfunction

  task automatic chk(input string tag, input logic [639:0] obs,
                     input logic [639:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_pkt(input int p, input int k, input int len);
    for (int b = 0; b < len; b++) exp_q.push_back(beat(p, k, b, len));
  endtask

  task automatic drive();
    logic l0, l1;
    l0 = (s_beat[0] == s_len[0] - 1);
    l1 = (s_beat[1] == s_len[1] - 1);
    in0_tvalid = (s_left[0] > 0);
    in0_tdata  = dat(0, s_pkt[0], s_beat[0]);
    in0_tkeep  = kp(l0);
    in0_tlast  = l0;
    in0_tuser  = l0 & (s_pkt[0] % 2 == 1);
    in1_tvalid = (s_left[1] > 0);
    in1_tdata  = dat(1, s_pkt[1], s_beat[1]);
    in1_tkeep  = kp(l1);
    in1_tlast  = l1;
    in1_tuser  = l1 & (s_pkt[1] % 2 == 1);
  endtask

  task automatic advance(input int p);
    if (s_beat[p] == s_len[p] - 1) begin
      s_beat[p] = 0;
      s_pkt[p]++;
      s_left[p]--;
    end else begin
      s_beat[p]++;
    end
  endtask

  task automatic tick();
    logic h0, h1;
    logic [639:0] e;
    #1;
    h0 = in0_tvalid & in0_tready;
    h1 = in1_tvalid & in1_tready;
    if (noout_chk) chk("drop_no_out", out_tvalid, 0);
    if (bp_chk && out_tvalid) begin
      chk("rdy_mirror", in0_tready, out_tready);
      chk("rdy_other", in1_tready, 0);
    end
    if (mon_en && out_tvalid && out_tready) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      chk("out_beat", {62'b0, out_tuser, out_tlast, out_tkeep, out_tdata}, e);
      if (gap_en && out_sop && last_tl >= 0) chk("gap", cyc - last_tl, 2);
      out_sop = out_tlast;
      if (out_tlast) last_tl = cyc;
    end
    @(posedge rx_clk);
    cyc++;
    #1;
    if (h0) advance(0);
    if (h1) advance(1);
    if (bp_tog) out_tready = ~out_tready;
    if (lk_port >= 0 && s_left[lk_port] > 0 && s_beat[lk_port] == 1)
      link_up = lk_val;
    drive();
  endtask

  task automatic run(input int maxc);
    int n;
    n = 0;
    while (!(s_left[0] == 0 && s_left[1] == 0 && exp_q.size() == 0)
           && n < maxc) begin
      tick();
      n++;
    end
    chk("done_in_budget", (n < maxc), 1);
  endtask

  initial begin
    rx_reset   = 1'b1;
    link_up    = 1'b1;
    out_tready = 1'b1;
    s_len  = '{1, 1};
    s_beat = '{0, 0};
    s_pkt  = '{0, 0};
    s_left = '{0, 0};
    drive();
    repeat (2) tick();
    rx_reset = 1'b0;
    #1;
    chk("rst_out_tvalid", out_tvalid, 0);
    chk("rst_in0_tready", in0_tready, 0);
    chk("rst_in1_tready", in1_tready, 0);
    chk("rst_pkt0", pkt_count0, 0);
    chk("rst_pkt1", pkt_count1, 0);
    chk("rst_drop", drop_count, 0);

    // single port, 4 beats
    s_len[0] = 4; s_pkt[0] = 0; s_left[0] = 1;
    exp_pkt(0, 0, 4);
    drive();
    #1;
    chk("bubble_tvalid", out_tvalid, 0);
    chk("bubble_tready", in0_tready, 0);
    tick();
    #1;
    chk("lat1_tvalid", out_tvalid, 1);
    chk("lat1_in1_tready", in1_tready, 0);
    run(20);
    chk("single_pkt0", pkt_count0, ce(1));

    // contention after a reset so port0 has priority
    rx_reset = 1'b1;
    tick();
    rx_reset = 1'b0;
    s_len = '{3, 3}; s_pkt = '{10, 10}; s_left = '{4, 4};
    for (int i = 0; i < 4; i++) begin
      exp_pkt(0, 10 + i, 3);
      exp_pkt(1, 10 + i, 3);
    end
    out_sop = 1'b1; last_tl = -1; gap_en = 1'b1;
    drive();
    run(60);
    gap_en = 1'b0;
    chk("cont_pkt0", pkt_count0, ce(4));
    chk("cont_pkt1", pkt_count1, ce(4));

    // backpressure on a 5-beat packet
    s_len[0] = 5; s_left[0] = 1;
    exp_pkt(0, s_pkt[0], 5);
    bp_chk = 1'b1; bp_tog = 1'b1;
    drive();
    run(40);
    bp_chk = 1'b0; bp_tog = 1'b0; out_tready = 1'b1;
    chk("bp_pkt0", pkt_count0, ce(5));

    // link down: two 2-beat packets on port1 dropped
    link_up = 1'b0;
    s_len[1] = 2; s_left[1] = 2;
    drive();
    tick();
    #1;
    chk("drop_in1_tready", in1_tready, 1);
    chk("drop_in0_tready", in0_tready, 0);
    noout_chk = 1'b1;
    run(20);
    noout_chk = 1'b0;
    chk("drop_count2", drop_count, ce(2));
    chk("drop_pkt1", pkt_count1, ce(4));

    // link lost during beat 2 of a 6-beat SEND
    link_up = 1'b1;
    s_len[0] = 6; s_left[0] = 1;
    exp_pkt(0, s_pkt[0], 6);
    lk_port = 0; lk_val = 1'b0;
    drive();
    run(30);
    chk("linkloss_pkt0", pkt_count0, ce(6));
    chk("linkloss_link", link_up, 0);

    // link regained during beat 2 of a DROP; next packet forwarded
    s_len[1] = 3; s_left[1] = 2;
    exp_pkt(1, s_pkt[1] + 1, 3);
    lk_port = 1; lk_val = 1'b1;
    drive();
    run(30);
    lk_port = -1;
    chk("linkup_drop", drop_count, ce(3));
    chk("linkup_pkt1", pkt_count1, ce(5));

    // reset during beat 3 of a 5-beat packet
    mon_en = 1'b0;
    s_len[0] = 5; s_pkt[0] = 20; s_beat[0] = 0; s_left[0] = 1;
    drive();
    for (int n = 0; n < 10 && s_beat[0] != 2; n++) tick();
    chk("rst_mid_at_beat3", s_beat[0], 2);
    rx_reset = 1'b1;
    tick();
    rx_reset = 1'b0;
    s_len = '{2, 2}; s_beat = '{0, 0}; s_pkt = '{21, 21}; s_left = '{1, 1};
    drive();
    #1;
    chk("rmid_out_tvalid", out_tvalid, 0);
    chk("rmid_in0_tready", in0_tready, 0);
    chk("rmid_in1_tready", in1_tready, 0);
    chk("rmid_pkt0", pkt_count0, 0);
    chk("rmid_pkt1", pkt_count1, 0);
    chk("rmid_drop", drop_count, 0);
    exp_q.delete();
    exp_pkt(0, 21, 2);
    exp_pkt(1, 21, 2);
    out_sop = 1'b1;
    mon_en = 1'b1;
    run(20);
    chk("post_rst_pkt0", pkt_count0, ce(1));
    chk("post_rst_pkt1", pkt_count1, ce(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
